// File: rtl/vid_pkg.sv
// Shared video definitions: 1080p60 timing constants, counter width,
// pattern-mode encodings and small helpers for the timing generator.
package vid_pkg;

  localparam int CNT_W = 12;

  localparam int H_ACTIVE = 1920;
  localparam int H_FP     = 88;
  localparam int H_SYNC   = 44;
  localparam int H_TOTAL  = 2200;

  localparam int V_ACTIVE = 1080;
  localparam int V_FP     = 4;
  localparam int V_SYNC   = 5;
  localparam int V_TOTAL  = 1125;

  typedef enum logic [2:0] {
    PAT_BARS    = 3'd0,
    PAT_RAMP    = 3'd1,
    PAT_CHECKER = 3'd2,
    PAT_SOLID   = 3'd3,
    PAT_MOVE    = 3'd4
  } pat_mode_e;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } tim_t;

  // Half-open window test on a counter, done one bit wider than the
  // counter so that lo/hi sums near the top of the range cannot wrap.
  function automatic logic in_win(
    input logic [CNT_W-1:0] c,
    input logic [CNT_W:0]   lo,
    input logic [CNT_W:0]   hi
  );
    return ({1'b0, c} >= lo) && ({1'b0, c} < hi);
  endfunction

endpackage

// File: rtl/vtg_delay_line.sv
// Enable-gated shift register with a per-stage reset value; realigns
// the raster control bits with downstream registered pixel data.
module vtg_delay_line #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [DEPTH];

  // Shift one stage per enabled cycle; reset loads every stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= RST_VAL;
      end
    end else if (en) begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: undelayed hcnt/vcnt plus delayed sync/DE.
// Optional frame counter port enabled by defining VTG_FRAME_CNT_EN.
module video_timing_gen
  import vid_pkg::*;
#(
  parameter int   ACTIVE_H = H_ACTIVE,
  parameter int   FP_H     = H_FP,
  parameter int   SYNC_H   = H_SYNC,
  parameter int   TOTAL_H  = H_TOTAL,
  parameter int   ACTIVE_V = V_ACTIVE,
  parameter int   FP_V     = V_FP,
  parameter int   SYNC_V   = V_SYNC,
  parameter int   TOTAL_V  = V_TOTAL,
  parameter logic SYNC_POL = 1'b1,
  parameter int   PIPE_DLY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  if ((TOTAL_H < ACTIVE_H + FP_H + SYNC_H + 1) ||
      (TOTAL_V < ACTIVE_V + FP_V + SYNC_V + 1) ||
      (TOTAL_H > (1 << CNT_W)) ||
      (TOTAL_V > (1 << CNT_W)) ||
      (PIPE_DLY < 1) || (PIPE_DLY > 4)) begin : g_bad_cfg
    $error("video_timing_gen: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(TOTAL_H - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(TOTAL_V - 1);

  localparam logic [CNT_W:0] H_ACT  = (CNT_W+1)'(ACTIVE_H);
  localparam logic [CNT_W:0] V_ACT  = (CNT_W+1)'(ACTIVE_V);
  localparam logic [CNT_W:0] HS_LO  = (CNT_W+1)'(ACTIVE_H + FP_H);
  localparam logic [CNT_W:0] HS_HI  =
    (CNT_W+1)'(ACTIVE_H + FP_H + SYNC_H);
  localparam logic [CNT_W:0] VS_LO  = (CNT_W+1)'(ACTIVE_V + FP_V);
  localparam logic [CNT_W:0] VS_HI  =
    (CNT_W+1)'(ACTIVE_V + FP_V + SYNC_V);

  localparam tim_t TIM_RST = '{
    de: 1'b0,
    hs: ~SYNC_POL,
    vs: ~SYNC_POL
  };

  logic h_last;
  logic v_last;
  logic hs_act;
  logic vs_act;
  tim_t raw;
  tim_t dly;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // Pixel counter wraps every line; line counter steps on that wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (en) begin
      if (h_last) begin
        hcnt <= '0;
        if (v_last) begin
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + CNT_W'(1);
        end
      end else begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end

  // Raw raster decode straight from the counters.
  always_comb begin
    hs_act = in_win(hcnt, HS_LO, HS_HI);
    vs_act = in_win(vcnt, VS_LO, VS_HI);
    raw.de = ({1'b0, hcnt} < H_ACT) && ({1'b0, vcnt} < V_ACT);
    raw.hs = SYNC_POL ? hs_act : ~hs_act;
    raw.vs = SYNC_POL ? vs_act : ~vs_act;
  end

  assign line_start  = en && (hcnt == '0);
  assign frame_start = line_start && (vcnt == '0);

  vtg_delay_line #(
    .W       (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (TIM_RST)
  ) u_dly (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (raw),
    .q     (dly)
  );

  assign de_o    = dly.de;
  assign hsync_o = dly.hs;
  assign vsync_o = dly.vs;

`ifdef VTG_FRAME_CNT_EN
  // Count frames on the cycle where both counters wrap together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (en && h_last && v_last) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench: a 1080p instance and a tiny-raster
// instance (PIPE_DLY=3, active-low sync) checked against a t-based model.
module tb_video_timing_gen;

  typedef struct {
    int ah, fh, sh, th;
    int av, fv, sv, tv;
    int d;
    bit pol;
  } cfg_t;

  typedef struct {
    int h, v, fc;
    bit ls, fs, de, hs, vs;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  localparam int NCYC = 27000;
  localparam int PH1  = 6000;

  logic clk;
  logic reset;
  logic en;

  logic [11:0] a_hcnt, a_vcnt, b_hcnt, b_vcnt;
  logic a_ls, a_fs, a_hs, a_vs, a_de;
  logic b_ls, b_fs, b_hs, b_vs, b_de;
`ifdef VTG_FRAME_CNT_EN
  logic [7:0] a_fc, b_fc;
`endif

  pair_t sb[$];
  int nvec = 0;
  int nmis = 0;
  cfg_t ca, cb;
  longint t;

  video_timing_gen u_a (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .hcnt        (a_hcnt),
    .vcnt        (a_vcnt),
    .line_start  (a_ls),
    .frame_start (a_fs),
    .hsync_o     (a_hs),
    .vsync_o     (a_vs),
    .de_o        (a_de)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_cnt   (a_fc)
`endif
  );

  video_timing_gen #(
    .ACTIVE_H (6),
    .FP_H     (1),
    .SYNC_H   (2),
    .TOTAL_H  (10),
    .ACTIVE_V (4),
    .FP_V     (1),
    .SYNC_V   (1),
    .TOTAL_V  (7),
    .SYNC_POL (1'b0),
    .PIPE_DLY (3)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .hcnt        (b_hcnt),
    .vcnt        (b_vcnt),
    .line_start  (b_ls),
    .frame_start (b_fs),
    .hsync_o     (b_hs),
    .vsync_o     (b_vs),
    .de_o        (b_de)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_cnt   (b_fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: t = enabled edges since reset; position and delayed
  // outputs follow directly from t by division and modulo.
  function automatic exp_t model(
    input longint tt,
    input bit     e_n,
    input cfg_t   c
  );
    exp_t   e;
    longint q;
    int     qh, qv;
    e.h  = int'(tt % c.th);
    e.v  = int'((tt / c.th) % c.tv);
    e.fc = int'((tt / (c.th * c.tv)) % 256);
    e.ls = e_n && (e.h == 0);
    e.fs = e.ls && (e.v == 0);
    if (tt < c.d) begin
      e.de = 1'b0;
      e.hs = !c.pol;
      e.vs = !c.pol;
    end else begin
      q  = tt - c.d;
      qh = int'(q % c.th);
      qv = int'((q / c.th) % c.tv);
      e.de = (qh < c.ah) && (qv < c.av);
      e.hs = (qh >= c.ah + c.fh && qh < c.ah + c.fh + c.sh)
             ? c.pol : !c.pol;
      e.vs = (qv >= c.av + c.fv && qv < c.av + c.fv + c.sv)
             ? c.pol : !c.pol;
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, req, $time);
    end
  endtask

  // Stimulus: random en, sparse resets early, push expectation.
  initial begin
    int hold;
    ca = '{1920, 88, 44, 2200, 1080, 4, 5, 1125, 1, 1'b1};
    cb = '{6, 1, 2, 10, 4, 1, 1, 7, 3, 1'b0};
    en    = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    t    = 0;
    hold = 3;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (en && reset) t++;
      if (hold > 0) begin
        reset = 1'b0;
        hold--;
      end else begin
        reset = 1'b1;
      end
      if (c < 25) en = 1'b1;
      else if (c >= 4000 && c < 4010) en = 1'b0;
      else if (c < PH1) en = ($urandom_range(0, 9) != 0);
      else en = ($urandom_range(0, 19) != 0);
      if (!reset) t = 0;
      sb.push_back('{model(t, en, ca), model(t, en, cb)});
      if (reset && c < PH1 &&
          (c == 3000 || $urandom_range(0, 1999) == 0)) begin
        hold = $urandom_range(1, 3);
      end
    end
    @(negedge clk);
    #2;
    cmp("queue_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

  // Monitor: sample just after the falling edge and check both DUTs.
  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
        p = sb.pop_front();
        cmp("a_hcnt", int'(a_hcnt), p.a.h);
        cmp("a_vcnt", int'(a_vcnt), p.a.v);
        cmp("a_line_start", int'(a_ls), int'(p.a.ls));
        cmp("a_frame_start", int'(a_fs), int'(p.a.fs));
        cmp("a_de_o", int'(a_de), int'(p.a.de));
        cmp("a_hsync_o", int'(a_hs), int'(p.a.hs));
        cmp("a_vsync_o", int'(a_vs), int'(p.a.vs));
        cmp("b_hcnt", int'(b_hcnt), p.b.h);
        cmp("b_vcnt", int'(b_vcnt), p.b.v);
        cmp("b_line_start", int'(b_ls), int'(p.b.ls));
        cmp("b_frame_start", int'(b_fs), int'(p.b.fs));
        cmp("b_de_o", int'(b_de), int'(p.b.de));
        cmp("b_hsync_o", int'(b_hs), int'(p.b.hs));
        cmp("b_vsync_o", int'(b_vs), int'(p.b.vs));
`ifdef VTG_FRAME_CNT_EN
        cmp("a_frame_cnt", int'(a_fc), p.a.fc);
        cmp("b_frame_cnt", int'(b_fc), p.b.fc);
`endif
      end
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator for the 1080p60 display path; sits directly upstream of the RGB pattern generator.
- Produces active-relative pixel and line counters (hcnt/vcnt) that the pattern generator consumes.
- Produces sync and data-enable outputs delayed by PIPE_DLY cycles so they line up with the pattern generator's registered R/G/B.
- Line order, horizontal and vertical: active, front porch, sync, back porch. Count 0 is the first active pixel / line.

Parameters:
- ACTIVE_H, 1920, active pixels per line
- FP_H, 88, horizontal front porch, in pixels
- SYNC_H, 44, hsync width, in pixels
- TOTAL_H, 2200, total pixels per line
- ACTIVE_V, 1080, active lines per frame
- FP_V, 4, vertical front porch, in lines
- SYNC_V, 5, vsync width, in lines
- TOTAL_V, 1125, total lines per frame
- SYNC_POL, 1, active level of hsync/vsync (1 = active-high)
- PIPE_DLY, 1, cycles of delay on hsync_o/vsync_o/de_o; legal range 1..4

Ports:
- clk  input  1  pixel clock (148.5 MHz)
- reset  input  1  reset; asynchronous, active-low
- en  input  1  count enable; low freezes all state
- hcnt  output  12  pixel counter, 0..TOTAL_H-1, not delayed
- vcnt  output  12  line counter, 0..TOTAL_V-1, not delayed
- line_start  output  1  high while hcnt==0 and en==1
- frame_start  output  1  high while hcnt==0, vcnt==0 and en==1
- hsync_o  output  1  delayed hsync
- vsync_o  output  1  delayed vsync
- de_o  output  1  delayed data enable
- frame_cnt  output  8  frames completed; port exists only when VTG_FRAME_CNT_EN is defined

Behaviour:
- Reset (asynchronous, active-low clear):
  - hcnt=0, vcnt=0.
  - All delay stages: hsync/vsync at !SYNC_POL, de=0.
  - Therefore hsync_o=vsync_o=!SYNC_POL and de_o=0.
  - line_start/frame_start follow their equations (both are 0 while en=0).
  - A reset asserted mid-frame restarts timing at pixel 0 of line 0. No partial-state recovery.
- Counting, on each clk edge with en=1:
  - hcnt==TOTAL_H-1: hcnt<=0. Otherwise hcnt<=hcnt+1.
  - vcnt advances only on that hcnt wrap: vcnt==TOTAL_V-1 gives vcnt<=0, otherwise vcnt+1.
  - Both counters wrap in the same cycle at the end of a frame.
- en=0: counters and delay stages hold their values. Outputs are static.
- Raw signals (combinational from the counters):
  - de_r = (hcnt<ACTIVE_H) && (vcnt<ACTIVE_V).
  - hs_r active when ACTIVE_H+FP_H <= hcnt < ACTIVE_H+FP_H+SYNC_H.
  - vs_r active when ACTIVE_V+FP_V <= vcnt < ACTIVE_V+FP_V+SYNC_V.
  - vs_r transitions only at hcnt==0 boundaries.
- Delay line:
  - de_r/hs_r/vs_r pass through a PIPE_DLY-stage register line, advanced only when en=1.
  - The last stage drives de_o/hsync_o/vsync_o.
  - With PIPE_DLY=1, de_o is high during cycles where hcnt is in [1..1920] on active lines. This matches the 1-cycle R/G/B latency downstream.
- Arithmetic:
  - 12-bit unsigned counters.
  - Comparison sums are computed at 13 bits to avoid overflow.
  - Requirements: TOTAL_H >= ACTIVE_H+FP_H+SYNC_H+1, and likewise for V. Checked by elaboration assertion.

Optional Feature:
- Macro: VTG_FRAME_CNT_EN.
- Defined:
  - 8-bit frame_cnt, reset to 0.
  - Increments by 1 on the enabled cycle where both counters wrap (hcnt==TOTAL_H-1 and vcnt==TOTAL_V-1).
  - Wraps 255->0.
  - Used by the pattern generator for animated patterns.
- Undefined: port and register are absent. All other behaviour is identical.

Decomposition:
- Shared package vid_pkg holds:
  - 1080p timing constants (ACTIVE/FP/SYNC/TOTAL, H and V).
  - Counter width constant CNT_W=12.
  - Pattern-mode encodings shared with the RGB generator.
- One natural sub-module, vtg_delay_line: parameterised width and depth, enable-gated shift register with reset value. Instantiated once, 3 bits wide, PIPE_DLY deep.

Test Plan:
- Reset then en=1 for 3 cycles -> hcnt=3, vcnt=0; de_o=1 from the cycle with hcnt=1; hsync_o=vsync_o=0; frame_start=1 only at hcnt=0.
- Run one line -> hsync_o high exactly when hcnt is in 2009..2052 (44 cycles); de_o low from hcnt=1921 to end of line; line_start pulses at the wrap to 0 with vcnt=1.
- Run a full frame (2,475,000 enabled cycles) -> counters return to 0/0; frame_start pulses; vsync_o active on lines 1084..1088; de_o never high on lines 1080..1124; frame_cnt=1 with the macro defined.
- Toggle en low for 10 cycles at hcnt=500 -> hcnt, vcnt and all outputs frozen; counting resumes at 501.
- Assert reset at vcnt=600, hcnt=1000 -> outputs immediately at reset values; after release, counting restarts from 0/0.
- PIPE_DLY=3 -> de_o, hsync_o and vsync_o edges shift exactly 2 cycles later than with PIPE_DLY=1; hcnt and vcnt unchanged.
